cla_adder_pipe: RTL

Parametrised, pipelined carry-lookahead adder/subtractor; the next generation of the 16-bit combinational `cla_adder`. Operands are split into SEG-bit segments. Each pipeline stage resolves one segment with internal carry-lookahead and registers the carry into the next stage. A valid/ready handshake with full-pipeline stall lets it sit between streaming producers and consumers in the datapath.

---
 rtl/cla_adder_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: W-bit operands are resolved one SEG-bit segment per stage.
// Latency NSEG = W/SEG cycles from input handshake to out_valid; throughput one beat per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready combinationally.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand beat handshake (a, b, cin, sub)
//   a, b                  W-bit operands
//   cin                   carry-in for add, borrow-in for subtract
//   sub                   0 = a + b + cin, 1 = a - b - cin
//   out_valid / out_ready result beat handshake (s, cout, ovf)
//   s                     W-bit sum/difference
//   cout                  carry out of bit W-1 (subtract: 1 = no borrow)
//   ovf                   two's-complement signed overflow
module cla_adder_pipe #(
    parameter int W   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int NSEG = W / SEG;
    // Number of 4-bit lookahead groups in a segment; the top group may be partial.
    localparam int NGRP = (SEG + 3) / 4;

    generate
        if (SEG < 1 || (W % SEG) != 0) begin : g_bad_params
            $error("cla_adder_pipe: W must be a positive multiple of SEG");
        end
    endgenerate

    // Carries for one segment. Returned vector: c[i] is the carry into bit i,
    // c[0] = ci, c[SEG] = carry out of the segment. Bits are grouped by four;
    // each group's P/G is formed first, group carries are produced as flat
    // sum-of-products from ci and the group P/G, and bit carries inside a
    // group are again flat sum-of-products from that group's carry-in.
    function automatic logic [SEG:0] seg_carries(
        input logic [SEG-1:0] p,
        input logic [SEG-1:0] g,
        input logic           ci
    );
        logic [NGRP-1:0] gp;
        logic [NGRP-1:0] gg;
        logic [NGRP:0]   gc;
        logic [SEG:0]    c;
        logic            t;
        int              base;

        for (int j = 0; j < NGRP; j++) begin
            gp[j] = 1'b1;
            gg[j] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (4 * j + i < SEG) begin
                    gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
                    gp[j] = gp[j] & p[4*j+i];
                end
            end
        end

        for (int j = 0; j <= NGRP; j++) begin
            t = ci;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = t;
            for (int k = 0; k < j; k++) begin
                t = gg[k];
                for (int m = k + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end

        for (int i = 0; i < SEG; i++) begin
            base = (i / 4) * 4;
            t = gc[i/4];
            for (int m = base; m < i; m++) t = t & p[m];
            c[i] = t;
            for (int k = base; k < i; k++) begin
                t = g[k];
                for (int m = k + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        c[SEG] = gc[NGRP];
        return c;
    endfunction

    // st_*[k] are the values presented to stage k: operands (b already
    // conditionally inverted), sum bits resolved so far, incoming carry, valid.
    logic [W-1:0] st_a [NSEG];
    logic [W-1:0] st_b [NSEG];
    logic [W-1:0] st_s [NSEG];
    logic         st_c [NSEG];
    logic         st_v [NSEG];
    logic         adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtract as a + ~b + ~cin, so a borrow-in of 1 becomes a carry-in of 0.
    assign st_a[0] = a;
    assign st_b[0] = sub ? ~b : b;
    assign st_s[0] = '0;
    assign st_c[0] = cin ^ sub;
    assign st_v[0] = in_valid;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [SEG-1:0] seg_p;
        logic [SEG-1:0] seg_g;
        logic [SEG:0]   seg_c;
        logic [W-1:0]   sum_k;

        assign seg_p = st_a[k][k*SEG +: SEG] ^ st_b[k][k*SEG +: SEG];
        assign seg_g = st_a[k][k*SEG +: SEG] & st_b[k][k*SEG +: SEG];
        assign seg_c = seg_carries(seg_p, seg_g, st_c[k]);

        always_comb begin
            sum_k = st_s[k];
            sum_k[k*SEG +: SEG] = seg_p ^ seg_c[SEG-1:0];
        end

        if (k < NSEG - 1) begin : g_mid
            logic [W-1:0] a_q;
            logic [W-1:0] b_q;
            logic [W-1:0] s_q;
            logic         c_q;
            logic         v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                    s_q <= sum_k;
                    c_q <= seg_c[SEG];
                    v_q <= st_v[k];
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_s[k+1] = s_q;
            assign st_c[k+1] = c_q;
            assign st_v[k+1] = v_q;
        end else begin : g_last
            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    s         <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (adv) begin
                    out_valid <= st_v[k];
                    s         <= sum_k;
                    cout      <= seg_c[SEG];
                    ovf       <= seg_c[SEG] ^ seg_c[SEG-1];
                end
            end
        end
    end

endmodule
